z16_dmem_arbiter: RTL and testbench
===================================

Name: z16_dmem_arbiter

Overview:
Two-requester arbiter that shares the single-port Z16 data memory between the CPU load/store path (master 0) and a loader/debug port (master 1). It drives the memory's combinational-read / synchronous-write interface and grants one master per cycle using round-robin priority. Write data is forwarded to the memory; read data is returned to the winning master through a registered response.
An optional lock lets one master hold the memory across consecutive cycles, for example for read-modify-write. The lock is bounded so the other master cannot starve.

Parameters:
ADDR_W, 16, memory address width
DATA_W, 16, memory data width
MAX_LOCK, 4, max consecutive locked grants before a forced release when the other master is waiting (range 1..255)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
i_m0_req  in  1  master 0 access request
i_m0_wen  in  1  master 0: 1=write, 0=read
i_m0_lock  in  1  master 0 requests to keep the grant next cycle
i_m0_addr  in  ADDR_W  master 0 address
i_m0_wdata  in  DATA_W  master 0 write data
o_m0_gnt  out  1  master 0 granted this cycle
o_m0_rvalid  out  1  master 0 read data valid
o_m0_rdata  out  DATA_W  master 0 read data
i_m1_req, i_m1_wen, i_m1_lock, i_m1_addr, i_m1_wdata, o_m1_gnt, o_m1_rvalid, o_m1_rdata: same as master 0, for master 1
o_mem_addr  out  ADDR_W  memory address
o_mem_wen  out  1  memory write enable
o_mem_wdata  out  DATA_W  memory write data
i_mem_rdata  in  DATA_W  memory combinational read data

Behaviour:
- Reset (async, i_rst=1):
  - r_last=1, so master 0 wins the first tie.
  - r_lock_owner=none, r_lock_cnt=0.
  - o_mX_rvalid=0, o_mX_rdata=0.
  - o_mX_gnt=0, o_mem_wen=0, o_mem_addr=0, o_mem_wdata=0, forced while i_rst=1.
- Grant decision is combinational in the same cycle, from the req inputs and registered state. At most one gnt is high.
  - Only one master requesting: it is granted.
  - Both requesting, no active lock: the master != r_last is granted.
  - Active lock owned by master X, X requesting, r_lock_cnt < MAX_LOCK: X is granted regardless of r_last.
  - Active lock, r_lock_cnt == MAX_LOCK, other master requesting: the other master is granted and the lock is cleared.
  - Active lock, r_lock_cnt == MAX_LOCK, other master idle: X is granted again; the count saturates at MAX_LOCK.
- Memory drive:
  - Granted master's addr and wdata go to o_mem_addr and o_mem_wdata; o_mem_wen = granted wen.
  - No grant: all memory outputs are 0.
- State updates on posedge:
  - Any grant: r_last = granted index.
  - Lock start: granted with lock=1 and no active lock. Set owner=granted, r_lock_cnt=1.
  - Lock continue: owner granted again with lock=1. r_lock_cnt = min(cnt+1, MAX_LOCK).
  - Lock end: owner granted with lock=0, owner not requesting, or forced release. Set owner=none, cnt=0.
- Read response:
  - Granted read (wen=0): o_mX_rdata <= i_mem_rdata and o_mX_rvalid <= 1 on the next edge, so data is valid the cycle after gnt. Latency is exactly 1.
  - Otherwise o_mX_rvalid <= 0. o_mX_rdata holds its last value.
  - Writes produce no rvalid.
- Requesters hold req/addr/wen/wdata stable until they see gnt. The arbiter does not queue; an ungranted request is simply retried next cycle.
- Reset asserted mid-access: the in-flight rvalid is dropped and all state returns to its reset values; there is no partial write beyond the edge already taken.

Test Plan:
1. Reset, then m0 reads addr 0x0010 (mem holds 0xBEEF) -> o_m0_gnt=1 same cycle, o_mem_addr=0x0010; next cycle o_m0_rvalid=1, o_m0_rdata=0xBEEF; o_m1_rvalid stays 0.
2. Both masters request reads continuously for 4 cycles -> grants m0,m1,m0,m1; each rvalid pulses the cycle after its own gnt; never both gnt=1.
3. m1 writes 0x1234 to 0x0020 while m0 is idle -> o_mem_wen=1, o_mem_wdata=0x1234 for one cycle, no rvalid; a following m0 read of 0x0020 returns 0x1234.
4. MAX_LOCK=4, m1 holds req+lock while m0 requests continuously -> m1 granted 4 consecutive cycles, m0 granted on the 5th, lock cleared.
5. Locked m0 with m1 idle for 10 cycles -> m0 granted every cycle and r_lock_cnt saturates at 4; when m1 then requests, m1 is granted on the next cycle.
6. Assert i_rst asynchronously mid-cycle during an m0 read grant -> o_m0_gnt and o_mem_* go to 0 immediately, no rvalid the next cycle; after release, a tie is won by m0.

Source files
------------

// File: rtl/z16_dmem_arbiter_if.sv
// Bus bundle between the two Z16 data-memory requesters, the arbiter and the memory.
// slave = arbiter view; master = requesters plus memory (everything the arbiter does not drive).
interface z16_dmem_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              i_m0_req;
   logic              i_m0_wen;
   logic              i_m0_lock;
   logic [ADDR_W-1:0] i_m0_addr;
   logic [DATA_W-1:0] i_m0_wdata;
   logic              o_m0_gnt;
   logic              o_m0_rvalid;
   logic [DATA_W-1:0] o_m0_rdata;

   logic              i_m1_req;
   logic              i_m1_wen;
   logic              i_m1_lock;
   logic [ADDR_W-1:0] i_m1_addr;
   logic [DATA_W-1:0] i_m1_wdata;
   logic              o_m1_gnt;
   logic              o_m1_rvalid;
   logic [DATA_W-1:0] o_m1_rdata;

   logic [ADDR_W-1:0] o_mem_addr;
   logic              o_mem_wen;
   logic [DATA_W-1:0] o_mem_wdata;
   logic [DATA_W-1:0] i_mem_rdata;

   modport slave (
      input  i_m0_req, i_m0_wen, i_m0_lock, i_m0_addr, i_m0_wdata,
      output o_m0_gnt, o_m0_rvalid, o_m0_rdata,
      input  i_m1_req, i_m1_wen, i_m1_lock, i_m1_addr, i_m1_wdata,
      output o_m1_gnt, o_m1_rvalid, o_m1_rdata,
      output o_mem_addr, o_mem_wen, o_mem_wdata,
      input  i_mem_rdata
   );

   modport master (
      output i_m0_req, i_m0_wen, i_m0_lock, i_m0_addr, i_m0_wdata,
      input  o_m0_gnt, o_m0_rvalid, o_m0_rdata,
      output i_m1_req, i_m1_wen, i_m1_lock, i_m1_addr, i_m1_wdata,
      input  o_m1_gnt, o_m1_rvalid, o_m1_rdata,
      input  o_mem_addr, o_mem_wen, o_mem_wdata,
      output i_mem_rdata
   );
endinterface

// File: rtl/z16_dmem_arbiter.sv
// Round-robin arbiter sharing the single-port Z16 data memory between two masters, with a
// bounded lock; grant is combinational, read data returns registered one cycle after grant.
module z16_dmem_arbiter #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 16,
   parameter int MAX_LOCK = 4
) (
   input logic          i_clk,
   input logic          i_rst,
   z16_dmem_arbiter_if.slave bus
);
   localparam logic [7:0] MAX_C = 8'(MAX_LOCK);

   typedef enum logic [1:0] {LK_NONE = 2'd0, LK_M0 = 2'd1, LK_M1 = 2'd2} lock_e;

   lock_e             lock_q, lock_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              last_q, last_d;
   logic              gnt0, gnt1;
   logic              rv0_q, rv0_d, rv1_q, rv1_d;
   logic [DATA_W-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
   logic [ADDR_W-1:0] addr_sel;
   logic [DATA_W-1:0] wdata_sel;
   logic              wen_sel;

   // An owner under its budget keeps the memory; at the budget it yields only if the other waits.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      unique case (lock_q)
         LK_M0: begin
            if (bus.i_m0_req && (cnt_q < MAX_C || !bus.i_m1_req)) gnt0 = 1'b1;
            else if (bus.i_m1_req)                               gnt1 = 1'b1;
         end
         LK_M1: begin
            if (bus.i_m1_req && (cnt_q < MAX_C || !bus.i_m0_req)) gnt1 = 1'b1;
            else if (bus.i_m0_req)                               gnt0 = 1'b1;
         end
         default: begin
            if (bus.i_m0_req && bus.i_m1_req) begin
               gnt0 = last_q;
               gnt1 = !last_q;
            end else begin
               gnt0 = bus.i_m0_req;
               gnt1 = bus.i_m1_req;
            end
         end
      endcase
   end

   // Lock ends whenever the owner is not re-granted with lock held, including forced release.
   always_comb begin
      last_d = last_q;
      lock_d = lock_q;
      cnt_d  = cnt_q;
      if (gnt0)      last_d = 1'b0;
      else if (gnt1) last_d = 1'b1;
      unique case (lock_q)
         LK_M0: begin
            if (gnt0 && bus.i_m0_lock) begin
               cnt_d = (cnt_q == MAX_C) ? cnt_q : cnt_q + 8'd1;
            end else begin
               lock_d = LK_NONE;
               cnt_d  = 8'd0;
            end
         end
         LK_M1: begin
            if (gnt1 && bus.i_m1_lock) begin
               cnt_d = (cnt_q == MAX_C) ? cnt_q : cnt_q + 8'd1;
            end else begin
               lock_d = LK_NONE;
               cnt_d  = 8'd0;
            end
         end
         default: begin
            if (gnt0 && bus.i_m0_lock) begin
               lock_d = LK_M0;
               cnt_d  = 8'd1;
            end else if (gnt1 && bus.i_m1_lock) begin
               lock_d = LK_M1;
               cnt_d  = 8'd1;
            end
         end
      endcase
   end

   always_comb begin
      addr_sel  = '0;
      wdata_sel = '0;
      wen_sel   = 1'b0;
      if (gnt0) begin
         addr_sel  = bus.i_m0_addr;
         wdata_sel = bus.i_m0_wdata;
         wen_sel   = bus.i_m0_wen;
      end else if (gnt1) begin
         addr_sel  = bus.i_m1_addr;
         wdata_sel = bus.i_m1_wdata;
         wen_sel   = bus.i_m1_wen;
      end
   end

   always_comb begin
      rv0_d = gnt0 && !bus.i_m0_wen;
      rv1_d = gnt1 && !bus.i_m1_wen;
      rd0_d = rv0_d ? bus.i_mem_rdata : rd0_q;
      rd1_d = rv1_d ? bus.i_mem_rdata : rd1_q;
   end

   // Memory-side and grant outputs are held quiet for the whole time reset is asserted.
   assign bus.o_m0_gnt    = gnt0 && !i_rst;
   assign bus.o_m1_gnt    = gnt1 && !i_rst;
   assign bus.o_mem_addr  = i_rst ? '0 : addr_sel;
   assign bus.o_mem_wdata = i_rst ? '0 : wdata_sel;
   assign bus.o_mem_wen   = wen_sel && !i_rst;
   assign bus.o_m0_rvalid = rv0_q;
   assign bus.o_m1_rvalid = rv1_q;
   assign bus.o_m0_rdata  = rd0_q;
   assign bus.o_m1_rdata  = rd1_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         lock_q <= LK_NONE;
         cnt_q  <= 8'd0;
         last_q <= 1'b1;
         rv0_q  <= 1'b0;
         rv1_q  <= 1'b0;
         rd0_q  <= '0;
         rd1_q  <= '0;
      end else begin
         lock_q <= lock_d;
         cnt_q  <= cnt_d;
         last_q <= last_d;
         rv0_q  <= rv0_d;
         rv1_q  <= rv1_d;
         rd0_q  <= rd0_d;
         rd1_q  <= rd1_d;
      end
   end
endmodule

// File: tb/tb_z16_dmem_arbiter.sv
// Directed scenarios followed by random traffic, checked against a transaction-level model.
module tb_z16_dmem_arbiter;
   localparam int MAXL = 4;

   typedef struct {
      bit          req;
      bit          wen;
      bit          lock;
      logic [15:0] addr;
      logic [15:0] wdata;
   } mreq_t;

   logic i_clk = 1'b0;
   logic i_rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   z16_dmem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   z16_dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_LOCK(MAXL)) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus)
   );

   always #5 i_clk = ~i_clk;

   logic [15:0] mem [0:255];
   logic [15:0] ref_mem [0:255];
   assign bus.i_mem_rdata = mem[bus.o_mem_addr[7:0]];

   int          m_last, m_owner, m_cnt;
   bit          m_rv [2];
   logic [15:0] m_rd [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_last  = 1;
      m_owner = -1;
      m_cnt   = 0;
      m_rv    = '{0, 0};
      m_rd    = '{16'h0, 16'h0};
   endtask

   function automatic int model_pick(input bit r0, input bit r1);
      bit rq [2];
      rq = '{r0, r1};
      if (!r0 && !r1) return -1;
      if (m_owner >= 0 && rq[m_owner] && (m_cnt < MAXL || !rq[1 - m_owner])) return m_owner;
      if (r0 && r1) return (m_owner >= 0) ? 1 - m_owner : 1 - m_last;
      return r0 ? 0 : 1;
   endfunction

   task automatic drive(input mreq_t a, input mreq_t b);
      bus.i_m0_req = a.req; bus.i_m0_wen = a.wen; bus.i_m0_lock = a.lock;
      bus.i_m0_addr = a.addr; bus.i_m0_wdata = a.wdata;
      bus.i_m1_req = b.req; bus.i_m1_wen = b.wen; bus.i_m1_lock = b.lock;
      bus.i_m1_addr = b.addr; bus.i_m1_wdata = b.wdata;
   endtask

   // One clock of traffic: starts at a negedge, ends at the next negedge.
   task automatic step(input mreq_t a, input mreq_t b, output int win);
      mreq_t       w;
      logic        cap_wen;
      logic [15:0] cap_addr, cap_wdata;
      drive(a, b);
      #1;
      win = model_pick(a.req, b.req);
      w = (win == 1) ? b : a;
      chk("gnt0", bus.o_m0_gnt, win == 0);
      chk("gnt1", bus.o_m1_gnt, win == 1);
      chk("mem_wen", bus.o_mem_wen, (win >= 0) && w.wen);
      chk("mem_addr", bus.o_mem_addr, (win >= 0) ? w.addr : 16'h0);
      chk("mem_wdata", bus.o_mem_wdata, (win >= 0) ? w.wdata : 16'h0);
      cap_wen = bus.o_mem_wen; cap_addr = bus.o_mem_addr; cap_wdata = bus.o_mem_wdata;
      @(posedge i_clk);
      if (cap_wen) mem[cap_addr[7:0]] = cap_wdata;
      m_rv = '{0, 0};
      if (win >= 0) begin
         if (w.wen) ref_mem[w.addr[7:0]] = w.wdata;
         else begin
            m_rv[win] = 1;
            m_rd[win] = ref_mem[w.addr[7:0]];
         end
         m_last = win;
      end
      if (m_owner < 0) begin
         if (win >= 0 && w.lock) begin
            m_owner = win;
            m_cnt = 1;
         end
      end else if (win == m_owner && w.lock) begin
         m_cnt = (m_cnt + 1 > MAXL) ? MAXL : m_cnt + 1;
      end else begin
         m_owner = -1;
         m_cnt = 0;
      end
      @(negedge i_clk);
      chk("rvalid0", bus.o_m0_rvalid, m_rv[0]);
      chk("rvalid1", bus.o_m1_rvalid, m_rv[1]);
      chk("rdata0", bus.o_m0_rdata, m_rd[0]);
      chk("rdata1", bus.o_m1_rdata, m_rd[1]);
   endtask

   function automatic mreq_t rd(input logic [15:0] addr, input bit lock = 0);
      mreq_t r;
      r = '{req: 1, wen: 0, lock: lock, addr: addr, wdata: 16'h0};
      return r;
   endfunction

   initial begin
      mreq_t idle, p [2];
      int    win;
      int    m0_gnts;
      idle = '{req: 0, wen: 0, lock: 0, addr: 16'h0, wdata: 16'h0};
      for (int i = 0; i < 256; i++) begin
         mem[i]     = 16'(i) ^ 16'h5A5A;
         ref_mem[i] = 16'(i) ^ 16'h5A5A;
      end
      mem[8'h10] = 16'hBEEF;
      ref_mem[8'h10] = 16'hBEEF;
      model_reset();

      // Reset state with a request pending: nothing may be granted or driven.
      drive(rd(16'h0010), rd(16'h0020));
      #3;
      chk("rst_gnt0", bus.o_m0_gnt, 0);
      chk("rst_gnt1", bus.o_m1_gnt, 0);
      chk("rst_mem_addr", bus.o_mem_addr, 0);
      chk("rst_mem_wen", bus.o_mem_wen, 0);
      chk("rst_rvalid", {bus.o_m0_rvalid, bus.o_m1_rvalid}, 0);
      chk("rst_rdata", {bus.o_m0_rdata, bus.o_m1_rdata}, 0);
      drive(idle, idle);
      @(negedge i_clk);
      i_rst = 1'b0;

      // 1: single m0 read
      step(rd(16'h0010), idle, win);
      chk("t1_rdata_beef", bus.o_m0_rdata, 16'hBEEF);
      step(idle, idle, win);

      // 3: m1 write (m0 idle)
      step(idle, '{req: 1, wen: 1, lock: 0, addr: 16'h0020, wdata: 16'h1234}, win);
      chk("t3_write_winner", win, 1);

      // 2: both read continuously, strict alternation m0,m1,m0,m1
      for (int i = 0; i < 4; i++) begin
         step(rd(16'h0030), rd(16'h0040), win);
         chk("t2_alternate", win, i % 2);
      end

      // 3 continued: read-back of the written word
      step(rd(16'h0020), idle, win);
      chk("t3_readback", bus.o_m0_rdata, 16'h1234);

      // 4: m1 locks while m0 waits; m0 must get in after MAX_LOCK m1 grants
      for (int i = 0; i < MAXL; i++) begin
         step(rd(16'h0050), rd(16'h0060, 1), win);
         chk("t4_lock_hold", win, 1);
      end
      step(rd(16'h0050), rd(16'h0060, 1), win);
      chk("t4_forced_release", win, 0);
      step(idle, idle, win);

      // 5: m0 locked alone for 10 cycles, then m1 arrives and is served at once
      for (int i = 0; i < 10; i++) begin
         step(rd(16'(16'h0070 + i), 1), idle, win);
         chk("t5_lock_alone", win, 0);
      end
      step(rd(16'h0070, 1), rd(16'h0080), win);
      chk("t5_starve_guard", win, 1);
      step(idle, idle, win);

      // 6: reset asserted mid-cycle during an m0 read grant
      drive(rd(16'h0010), idle);
      #1;
      chk("t6_pre_gnt0", bus.o_m0_gnt, 1);
      #2;
      i_rst = 1'b1;
      #1;
      chk("t6_gnt0_drop", bus.o_m0_gnt, 0);
      chk("t6_mem_addr_drop", bus.o_mem_addr, 0);
      chk("t6_mem_wen_drop", bus.o_mem_wen, 0);
      @(posedge i_clk);
      #1;
      chk("t6_no_rvalid", bus.o_m0_rvalid, 0);
      @(negedge i_clk);
      i_rst = 1'b0;
      model_reset();
      step(rd(16'h0011), rd(16'h0012), win);
      chk("t6_tie_m0", win, 0);

      // Random traffic: requesters hold their request until granted.
      p[0] = idle;
      p[1] = idle;
      m0_gnts = 0;
      for (int c = 0; c < 400; c++) begin
         for (int m = 0; m < 2; m++) begin
            if (!p[m].req && $urandom_range(0, 2) != 0) begin
               p[m].req   = 1;
               p[m].wen   = 1'($urandom_range(0, 1));
               p[m].addr  = {8'h00, 8'($urandom)};
               p[m].wdata = 16'($urandom);
            end
            p[m].lock = p[m].req && ($urandom_range(0, 2) == 0);
         end
         step(p[0], p[1], win);
         if (win == 0) m0_gnts++;
         if (win >= 0) p[win].req = 0;
      end
      chk("rand_m0_served", m0_gnts > 0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
